// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if
//   Bundles the request/acknowledge handshakes of the two requesters and the
//   result path of the shared binary-to-BCD converter.
//   Optional feature macro: BCD_BLANK_EN adds the leading-zero blank vector.
// Signals
//   req_a / req_b      requester A / B conversion request (level)
//   bin_a / bin_b      requester A / B binary value, sampled on grant
//   ack_a / ack_b      one-cycle grant pulse per requester
//   busy               conversion in progress
//   bcd_out            registered BCD result, digit NDIG-1 most significant
//   bcd_valid          one-cycle pulse marking a result update
//   bcd_id             source of the current result (0 = A, 1 = B)
//   ovf                input exceeded 10^NDIG-1, result saturated to all nines
//   blank              (BCD_BLANK_EN only) per-digit leading-zero blank flags
// Modports
//   master             requester / display side
//   slave              converter side
interface bcd_conv_sched_if #(
  parameter int BIN_W = 15,
  parameter int NDIG  = 4
);
  logic              req_a;
  logic [BIN_W-1:0]  bin_a;
  logic              ack_a;
  logic              req_b;
  logic [BIN_W-1:0]  bin_b;
  logic              ack_b;
  logic              busy;
  logic [4*NDIG-1:0] bcd_out;
  logic              bcd_valid;
  logic              bcd_id;
  logic              ovf;
`ifdef BCD_BLANK_EN
  logic [NDIG-1:0]   blank;
`endif

  modport master (
    output req_a, bin_a, req_b, bin_b,
    input  ack_a, ack_b, busy, bcd_out, bcd_valid, bcd_id, ovf
`ifdef BCD_BLANK_EN
    , input blank
`endif
  );

  modport slave (
    input  req_a, bin_a, req_b, bin_b,
    output ack_a, ack_b, busy, bcd_out, bcd_valid, bcd_id, ovf
`ifdef BCD_BLANK_EN
    , output blank
`endif
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched
//   Sequential binary-to-BCD converter shared by two requesters (A = live
//   weight, B = tare/reference). A round-robin arbiter grants one request at a
//   time; a shift-add-3 (double dabble) core processes one input bit per clock.
//   Each conversion takes BIN_W+1 cycles from grant to the next possible grant.
//   Optional feature macro: BCD_BLANK_EN adds the registered blank vector.
// Parameters
//   BIN_W   width of binary inputs and number of shift cycles per conversion
//   NDIG    number of BCD digits produced
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     bcd_conv_sched_if slave modport (handshakes and result path)
module bcd_conv_sched #(
  parameter int BIN_W = 15,
  parameter int NDIG  = 4
) (
  input logic             clk,
  input logic             rst_n,
  bcd_conv_sched_if.slave bus
);

  localparam int              DW      = 4 * NDIG;
  localparam int              CW      = $clog2(BIN_W + 1);
  localparam int unsigned     MAXV    = 10**NDIG - 1;
  localparam logic [CW-1:0]   LAST    = CW'(BIN_W - 1);
  localparam logic [DW-1:0]   SAT_VAL = {NDIG{4'h9}};
  localparam logic            ID_A    = 1'b0;
  localparam logic            ID_B    = 1'b1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [DW-1:0]    digits;
  logic [DW-1:0]    dig_adj;
  logic [DW-1:0]    dig_nxt;
  logic [BIN_W-1:0] shreg;
  logic [BIN_W-1:0] sh_nxt;
  logic [CW-1:0]    cnt;
  logic             rr_last;
  logic             ovf_pend;
  logic             grant_a;
  logic             grant_b;
  logic [BIN_W-1:0] bin_sel;
  logic             sel_ovf;

  // One double-dabble step: every digit >= 5 gets +3 (4-bit wrap, no carry
  // between digits), then the digit and binary registers shift left as one.
  always_comb begin
    dig_adj = digits;
    for (int i = 0; i < NDIG; i++) begin
      if (digits[4*i +: 4] >= 4'd5)
        dig_adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
    end
    {dig_nxt, sh_nxt} = {dig_adj, shreg} << 1;
  end

  // Round-robin arbitration: on a tie, the side that was not served last wins.
  // rr_last resets to B so that A takes the first tie.
  always_comb begin
    grant_a = bus.req_a & (~bus.req_b | (rr_last == ID_B));
    grant_b = bus.req_b & ~grant_a;
    bin_sel = grant_a ? bus.bin_a : bus.bin_b;
    sel_ovf = 32'(bin_sel) > MAXV;
  end

`ifdef BCD_BLANK_EN
  logic [NDIG-1:0] blank_nxt;
  logic            zero_above;

  // A digit is blanked when it and every more significant digit are zero.
  // The least significant digit is never blanked, and a saturated result
  // shows all nines so nothing is blanked.
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above   = zero_above & (dig_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = zero_above & ~ovf_pend;
    end
  end
`endif

  // Control FSM and all registered outputs. The grant edge captures the input
  // and clears the digits; each SHIFT edge performs one step, and the edge
  // doing the last step also publishes the result and returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      digits        <= '0;
      shreg         <= '0;
      cnt           <= '0;
      rr_last       <= ID_B;
      ovf_pend      <= 1'b0;
      bus.ack_a     <= 1'b0;
      bus.ack_b     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.bcd_out   <= '0;
      bus.bcd_valid <= 1'b0;
      bus.bcd_id    <= 1'b0;
      bus.ovf       <= 1'b0;
`ifdef BCD_BLANK_EN
      bus.blank     <= '0;
`endif
    end else begin
      bus.ack_a     <= 1'b0;
      bus.ack_b     <= 1'b0;
      bus.bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            bus.ack_a <= grant_a;
            bus.ack_b <= grant_b;
            rr_last   <= grant_b;
            shreg     <= bin_sel;
            digits    <= '0;
            cnt       <= '0;
            ovf_pend  <= sel_ovf;
            bus.busy  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          digits <= dig_nxt;
          shreg  <= sh_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.busy      <= 1'b0;
            bus.bcd_valid <= 1'b1;
            bus.bcd_out   <= ovf_pend ? SAT_VAL : dig_nxt;
            bus.bcd_id    <= rr_last;
            bus.ovf       <= ovf_pend;
`ifdef BCD_BLANK_EN
            bus.blank     <= blank_nxt;
`endif
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched
//   Directed, table-driven bench for bcd_conv_sched (BIN_W = 15, NDIG = 4).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Build with BCD_BLANK_EN defined to also check the blank vector.
module tb_bcd_conv_sched;

  localparam int BIN_W = 15;
  localparam int NDIG  = 4;
  localparam int LAT   = BIN_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  bcd_conv_sched_if #(.BIN_W(BIN_W), .NDIG(NDIG)) bus ();

  bcd_conv_sched #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        side;
    logic [14:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } vec_t;

  vec_t vecs[10];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic reqA, input logic [14:0] binA,
                               input logic reqB, input logic [14:0] binB);
    bus.req_a = reqA;
    bus.bin_a = binA;
    bus.req_b = reqB;
    bus.bin_b = binB;
  endtask

  // Called at the negedge where the ack is visible; waits (bounded) for
  // bcd_valid and checks latency, busy coverage and absence of stray acks.
  task automatic waitValid(input string name);
    int   lat;
    logic busyGap;
    logic ackExtra;
    lat      = 0;
    busyGap  = 1'b0;
    ackExtra = 1'b0;
    while (!bus.bcd_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!bus.bcd_valid && !bus.busy) busyGap = 1'b1;
      if (bus.ack_a || bus.ack_b) ackExtra = 1'b1;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
    checkOutput({name, "_busyGap"}, 32'(busyGap), 32'd0);
    checkOutput({name, "_strayAck"}, 32'(ackExtra), 32'd0);
    checkOutput({name, "_busyAtValid"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic checkResult(input string name, input logic [15:0] expBcd,
                             input logic expId, input logic expOvf,
                             input logic [3:0] expBlank);
    checkOutput({name, "_bcd"}, 32'(bus.bcd_out), 32'(expBcd));
    checkOutput({name, "_id"}, 32'(bus.bcd_id), 32'(expId));
    checkOutput({name, "_ovf"}, 32'(bus.ovf), 32'(expOvf));
`ifdef BCD_BLANK_EN
    checkOutput({name, "_blank"}, 32'(bus.blank), 32'(expBlank));
`else
    if (expBlank === 4'hx) $display("[TB] unexpected blank value");
`endif
  endtask

  // One full single-requester conversion, starting and ending at a negedge.
  task automatic runOne(input logic side, input logic [14:0] val,
                        input logic [15:0] expBcd, input logic expOvf,
                        input logic [3:0] expBlank, input string name);
    applyStimulus(~side, val, side, val);
    @(negedge clk);
    checkOutput({name, "_ackA"}, 32'(bus.ack_a), 32'(side == 1'b0));
    checkOutput({name, "_ackB"}, 32'(bus.ack_b), 32'(side == 1'b1));
    checkOutput({name, "_busy"}, 32'(bus.busy), 32'd1);
    // Scramble the inputs after ack; the running conversion must not notice.
    applyStimulus(1'b0, 15'h7fff, 1'b0, 15'h7fff);
    waitValid(name);
    checkResult(name, expBcd, side, expOvf, expBlank);
    @(negedge clk);
    checkOutput({name, "_validPulse"}, 32'(bus.bcd_valid), 32'd0);
    checkOutput({name, "_hold"}, 32'(bus.bcd_out), 32'(expBcd));
  endtask

  // Both requesters high on the same edge: A (42) first, then B (9999).
  task automatic tieSequence(input string name);
    applyStimulus(1'b1, 15'd42, 1'b1, 15'd9999);
    @(negedge clk);
    checkOutput({name, "_ackA"}, 32'(bus.ack_a), 32'd1);
    checkOutput({name, "_ackB"}, 32'(bus.ack_b), 32'd0);
    applyStimulus(1'b0, 15'd0, 1'b1, 15'd9999);
    waitValid({name, "_A"});
    checkResult({name, "_A"}, 16'h0042, 1'b0, 1'b0, 4'b1100);
    @(negedge clk);
    checkOutput({name, "_ackB2"}, 32'(bus.ack_b), 32'd1);
    checkOutput({name, "_ackA2"}, 32'(bus.ack_a), 32'd0);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0);
    waitValid({name, "_B"});
    checkResult({name, "_B"}, 16'h9999, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_ackA"}, 32'(bus.ack_a), 32'd0);
    checkOutput({name, "_ackB"}, 32'(bus.ack_b), 32'd0);
    checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_valid"}, 32'(bus.bcd_valid), 32'd0);
    checkResult(name, 16'h0000, 1'b0, 1'b0, 4'b0000);
  endtask

  // Idle for a number of cycles with no request: nothing may start.
  task automatic idleCheck(input string name, input int cycles);
    logic sawValid;
    logic sawBusy;
    sawValid = 1'b0;
    sawBusy  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      sawValid |= bus.bcd_valid;
      sawBusy  |= bus.busy;
    end
    checkOutput({name, "_noValid"}, 32'(sawValid), 32'd0);
    checkOutput({name, "_noBusy"}, 32'(sawBusy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 15'd1234,  16'h1234, 1'b0, 4'b0000};
    vecs[1] = '{1'b0, 15'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[2] = '{1'b0, 15'd9,     16'h0009, 1'b0, 4'b1110};
    vecs[3] = '{1'b1, 15'd42,    16'h0042, 1'b0, 4'b1100};
    vecs[4] = '{1'b0, 15'd9999,  16'h9999, 1'b0, 4'b0000};
    vecs[5] = '{1'b0, 15'd1000,  16'h1000, 1'b0, 4'b0000};
    vecs[6] = '{1'b1, 15'd1,     16'h0001, 1'b0, 4'b1110};
    vecs[7] = '{1'b1, 15'd10000, 16'h9999, 1'b1, 4'b0000};
    vecs[8] = '{1'b1, 15'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[9] = '{1'b1, 15'h7fff,  16'h9999, 1'b1, 4'b0000};

    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0);
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;
    idleCheck("idle", 20);

    tieSequence("tie1");
    tieSequence("tie2");

    for (int i = 0; i < 10; i++)
      runOne(vecs[i].side, vecs[i].bin, vecs[i].bcd, vecs[i].ovf,
             vecs[i].blank, $sformatf("vec%0d", i));

    // Abort: reset asserted just after the 7th shift edge of a conversion.
    applyStimulus(1'b1, 15'd5678, 1'b0, 15'd0);
    @(negedge clk);
    checkOutput("abort_ackA", 32'(bus.ack_a), 32'd1);
    applyStimulus(1'b0, 15'd0, 1'b0, 15'd0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetState("abortNow");
    repeat (3) @(negedge clk);
    checkResetState("abortHeld");
    rst_n = 1'b1;
    idleCheck("abortIdle", 20);
    runOne(1'b0, 15'd5678, 16'h5678, 1'b0, 4'b0000, "postAbort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
